// File: rtl/spwm_gate_driver.sv
// spwm_gate_driver: one half-bridge leg of the sine-PWM chain. It takes the
// triangle carrier and a modulation sample and produces a complementary
// gate pair with dead time. The incoming sample is double-buffered so the
// active compare value changes only at the carrier valley.
//
// Gate FSM
//   state | meaning
//   OFF   | both gates off; waiting for run=1 with no latched fault
//   DT_H  | dead time before the high side turns on
//   HI    | high-side gate conducting
//   DT_L  | dead time before the low side turns on
//   LO    | low-side gate conducting
module spwm_gate_driver #(
    parameter int width     = 6,
    parameter int cnt_max   = 41,
    parameter int dt_width  = 4,
    parameter int dead_time = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_syn,
    input  logic [width-1:0] carrier,
    input  logic             carryDown,
    input  logic [width-1:0] mod,
    input  logic             mod_valid,
    input  logic             run,
    input  logic             fault,
    output logic             mod_req,
    output logic             pwm_raw,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             fault_latched
);

    // One above the carrier peak: a compare at this value keeps pwm_raw high
    // across the whole carrier range.
    localparam logic [width-1:0]    CMP_TOP = width'(cnt_max + 1);
    localparam logic [dt_width-1:0] DT_LOAD = dt_width'(dead_time);
    localparam logic [dt_width-1:0] DT_LAST = dt_width'(1);

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        DT_H = 3'd1,
        HI   = 3'd2,
        DT_L = 3'd3,
        LO   = 3'd4
    } state_t;

    state_t              state;
    logic [dt_width-1:0] dt_cnt;
    logic [width-1:0]    pending;
    logic                pend_full;
    logic [width-1:0]    cmp;
    logic [width-1:0]    mod_clamped;

    assign mod_clamped = (mod > CMP_TOP) ? CMP_TOP : mod;

    // Sample double-buffer: new samples wait in pending, move to cmp at the valley.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            pend_full <= 1'b0;
            cmp       <= '0;
            mod_req   <= 1'b0;
        end else if (rst_syn) begin
            pending   <= '0;
            pend_full <= 1'b0;
            cmp       <= '0;
            mod_req   <= 1'b0;
        end else begin
            mod_req <= carryDown;
            if (carryDown) begin
                // A sample arriving on the valley itself bypasses the buffer.
                if (mod_valid) begin
                    cmp <= mod_clamped;
                end else if (pend_full) begin
                    cmp <= pending;
                end
                pend_full <= 1'b0;
            end else if (mod_valid) begin
                pending   <= mod_clamped;
                pend_full <= 1'b1;
            end
        end
    end

    // Registered comparator between the active compare value and the carrier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_raw <= 1'b0;
        end else if (rst_syn) begin
            pwm_raw <= 1'b0;
        end else begin
            pwm_raw <= (cmp > carrier);
        end
    end

    // Sticky fault flag; only a reset can clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_latched <= 1'b0;
        end else if (rst_syn) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end
    end

    // Gate FSM with dead-time down-counter; gate outputs track the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (rst_syn) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (!run || fault_latched) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state  <= pwm_raw ? DT_H : DT_L;
                    dt_cnt <= DT_LOAD;
                end
                DT_H: begin
                    // A raw pulse that ends inside the dead time restarts the
                    // wait toward the other side without ever turning on.
                    if (!pwm_raw) begin
                        state  <= DT_L;
                        dt_cnt <= DT_LOAD;
                    end else if (dt_cnt == DT_LAST) begin
                        state  <= HI;
                        pwm_hi <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - DT_LAST;
                    end
                end
                HI: begin
                    if (!pwm_raw) begin
                        state  <= DT_L;
                        dt_cnt <= DT_LOAD;
                        pwm_hi <= 1'b0;
                    end
                end
                DT_L: begin
                    if (pwm_raw) begin
                        state  <= DT_H;
                        dt_cnt <= DT_LOAD;
                    end else if (dt_cnt == DT_LAST) begin
                        state  <= LO;
                        pwm_lo <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - DT_LAST;
                    end
                end
                LO: begin
                    if (pwm_raw) begin
                        state  <= DT_H;
                        dt_cnt <= DT_LOAD;
                        pwm_lo <= 1'b0;
                    end
                end
                default: begin
                    state  <= OFF;
                    dt_cnt <= '0;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spwm_gate_driver.sv
// Directed bench for spwm_gate_driver: table of compare vectors followed by
// hand-written sequences for buffering, dead time, short pulses, run/fault
// gating and reset.
module tb_spwm_gate_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_syn;
    logic [5:0] carrier;
    logic       carryDown;
    logic [5:0] mod;
    logic       mod_valid;
    logic       run;
    logic       fault;
    logic       mod_req;
    logic       pwm_raw;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       fault_latched;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [5:0] mod;
        logic [5:0] carrier;
        logic       exp_raw;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    spwm_gate_driver dut (
        .clk          (clk),
        .rst          (rst),
        .rst_syn      (rst_syn),
        .carrier      (carrier),
        .carryDown    (carryDown),
        .mod          (mod),
        .mod_valid    (mod_valid),
        .run          (run),
        .fault        (fault),
        .mod_req      (mod_req),
        .pwm_raw      (pwm_raw),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .fault_latched(fault_latched)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_cmp(input logic [5:0] m);
        mod       = m;
        mod_valid = 1'b1;
        carryDown = 1'b1;
        step();
        mod_valid = 1'b0;
        carryDown = 1'b0;
    endtask

    task automatic chk_all_off(input string name);
        chk({name, "_hi"}, pwm_hi, 0);
        chk({name, "_lo"}, pwm_lo, 0);
        chk({name, "_raw"}, pwm_raw, 0);
        chk({name, "_req"}, mod_req, 0);
        chk({name, "_flt"}, fault_latched, 0);
    endtask

    initial begin
        int last_gate;
        int zeros;
        int swaps;
        int bad;
        int hi_seen;
        int lo_off;
        int c;

        vecs[0]  = '{6'd20, 6'd0,  1'b1};
        vecs[1]  = '{6'd20, 6'd19, 1'b1};
        vecs[2]  = '{6'd20, 6'd20, 1'b0};
        vecs[3]  = '{6'd20, 6'd41, 1'b0};
        vecs[4]  = '{6'd0,  6'd0,  1'b0};
        vecs[5]  = '{6'd0,  6'd41, 1'b0};
        vecs[6]  = '{6'd42, 6'd41, 1'b1};
        vecs[7]  = '{6'd41, 6'd41, 1'b0};
        vecs[8]  = '{6'd41, 6'd40, 1'b1};
        vecs[9]  = '{6'd63, 6'd41, 1'b1};
        vecs[10] = '{6'd63, 6'd42, 1'b0};
        vecs[11] = '{6'd63, 6'd50, 1'b0};
        vecs[12] = '{6'd5,  6'd4,  1'b1};
        vecs[13] = '{6'd5,  6'd5,  1'b0};

        rst = 1'b0; rst_syn = 1'b0; carrier = '0; carryDown = 1'b0;
        mod = '0; mod_valid = 1'b0; run = 1'b0; fault = 1'b0;

        // Reset state
        #12;
        chk_all_off("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        step(2);
        chk_all_off("post_reset");

        // Comparator / clamp vectors, each loaded on a valley
        for (int i = 0; i < 14; i++) begin
            mod       = vecs[i].mod;
            carrier   = vecs[i].carrier;
            mod_valid = 1'b1;
            carryDown = 1'b1;
            step();
            chk($sformatf("vec%0d_req", i), mod_req, 1);
            mod_valid = 1'b0;
            carryDown = 1'b0;
            step();
            chk($sformatf("vec%0d_raw", i), pwm_raw, vecs[i].exp_raw);
            chk($sformatf("vec%0d_req_end", i), mod_req, 0);
        end

        // Buffering: last sample wins, applied only at the valley
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
        carrier = 6'd25;
        mod = 6'd10; mod_valid = 1'b1;
        step();
        mod = 6'd30;
        step();
        mod_valid = 1'b0;
        step(3);
        chk("buf_no_early", pwm_raw, 0);
        carrier = 6'd29;
        carryDown = 1'b1;
        step();
        carryDown = 1'b0;
        chk("buf_req_hi", mod_req, 1);
        step();
        chk("buf_req_lo", mod_req, 0);
        chk("buf_cmp30_29", pwm_raw, 1);
        carrier = 6'd30;
        step();
        chk("buf_cmp30_30", pwm_raw, 0);
        carryDown = 1'b1;
        step();
        carryDown = 1'b0;
        carrier = 6'd29;
        step(2);
        chk("buf_hold", pwm_raw, 1);
        mod = 6'd5; mod_valid = 1'b1; carryDown = 1'b1; carrier = 6'd4;
        step();
        mod_valid = 1'b0; carryDown = 1'b0;
        step();
        chk("simul_4", pwm_raw, 1);
        carrier = 6'd5;
        step();
        chk("simul_5", pwm_raw, 0);

        // Dead time on a full carrier ramp with cmp=20
        carrier = 6'd0;
        load_cmp(6'd20);
        step();
        run = 1'b1;
        step(3);
        chk("start_wait", pwm_hi, 0);
        step();
        chk("start_hi", pwm_hi, 1);
        last_gate = 1; zeros = 0; swaps = 0;
        for (int i = 0; i < 168; i++) begin
            int idx;
            idx = i % 84;
            c = (idx < 42) ? idx : 83 - idx;
            carrier = 6'(c);
            step();
            chk("ramp_raw", pwm_raw, (c < 20) ? 1 : 0);
            chk("ramp_overlap", pwm_hi & pwm_lo, 0);
            if (pwm_hi) begin
                if (last_gate == 2) begin
                    chk("gap_lo_hi", zeros, 3);
                    swaps++;
                end
                last_gate = 1; zeros = 0;
            end else if (pwm_lo) begin
                if (last_gate == 1) begin
                    chk("gap_hi_lo", zeros, 3);
                    swaps++;
                end
                last_gate = 2; zeros = 0;
            end else begin
                zeros++;
            end
        end
        chk("ramp_swaps", (swaps >= 3) ? 1 : 0, 1);

        // Short raw pulse while in LO
        carrier = 6'd30;
        step(10);
        chk("sp_lo_steady", pwm_lo, 1);
        hi_seen = 0; lo_off = 0;
        for (int j = 0; j < 14; j++) begin
            carrier = (j < 2) ? 6'd10 : 6'd30;
            step();
            if (pwm_hi) hi_seen++;
            if (!pwm_lo) lo_off++;
        end
        chk("sp_hi_never", hi_seen, 0);
        chk("sp_lo_off_cycles", lo_off, 5);
        chk("sp_lo_back", pwm_lo, 1);

        // run gating
        carrier = 6'd10;
        step(8);
        chk("run_hi", pwm_hi, 1);
        run = 1'b0;
        step();
        chk("run_drop_hi", pwm_hi, 0);
        chk("run_drop_lo", pwm_lo, 0);
        run = 1'b1;
        step(3);
        chk("rerun_wait", pwm_hi, 0);
        step();
        chk("rerun_hi", pwm_hi, 1);

        // Extremes: mod=0 holds LO, mod=63 clamps and holds HI
        load_cmp(6'd0);
        step(6);
        bad = 0;
        for (int i = 0; i < 84; i++) begin
            c = (i < 42) ? i : 83 - i;
            carrier = 6'(c);
            step();
            if (pwm_hi || !pwm_lo) bad++;
        end
        chk("ext0_lo_steady", bad, 0);
        load_cmp(6'd63);
        step(6);
        bad = 0;
        for (int i = 0; i < 84; i++) begin
            c = (i < 42) ? i : 83 - i;
            carrier = 6'(c);
            step();
            if (!pwm_hi || pwm_lo || !pwm_raw) bad++;
        end
        chk("ext63_hi_steady", bad, 0);

        // Fault latch and clear
        fault = 1'b1;
        step();
        fault = 1'b0;
        chk("fault_set", fault_latched, 1);
        step();
        chk("fault_off_hi", pwm_hi, 0);
        chk("fault_off_lo", pwm_lo, 0);
        step(5);
        chk("fault_sticky", fault_latched, 1);
        chk("fault_stay_off", pwm_hi | pwm_lo, 0);
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
        chk("fault_clear", fault_latched, 0);
        chk("syn_off", pwm_hi | pwm_lo, 0);
        step(3);
        chk("reentry_wait", pwm_hi | pwm_lo, 0);
        step();
        chk("reentry_lo", pwm_lo, 1);

        // Asynchronous reset mid-HI
        load_cmp(6'd42);
        step(6);
        chk("arst_pre_hi", pwm_hi, 1);
        #3;
        rst = 1'b0;
        run = 1'b0;
        #1;
        chk("arst_hi_now", pwm_hi, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(3);
        chk_all_off("arst_idle");
        run = 1'b1;
        step(3);
        chk("arst_run_wait", pwm_hi | pwm_lo, 0);
        step();
        chk("arst_run_lo", pwm_lo, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spwm_gate_driver.md
# spwm_gate_driver

Converts the triangle carrier from the up/down carrier counter plus a modulation sample from the sine table into one complementary gate-drive pair for a single half-bridge leg. It double-buffers the modulation sample and updates the active compare value only at the carrier valley. It compares the sample against the carrier, then inserts dead time between high-side and low-side conduction. It also handles run and fault gating. The block sits directly downstream of the carrier counter, with one instance per phase leg.

## Interface
- width, 6, carrier and modulation word width (matches carrier counter)
- cnt_max, 41, carrier peak count; modulation samples above cnt_max+1 are clamped to cnt_max+1
- dt_width, 4, dead-time counter width
- dead_time, 3, dead-time length in clk cycles; legal range 1..2^dt_width-1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active low
- rst_syn  in  1  synchronous clear; same effect as rst, and also clears fault_latched
- carrier  in  width  carrier count from the counter
- carryDown  in  1  valley strobe from the counter (cnt==1 && e)
- mod  in  width  modulation sample
- mod_valid  in  1  one-cycle strobe; mod is valid this cycle
- run  in  1  1 = gate outputs allowed, 0 = both gates off
- fault  in  1  synchronous fault request; latches
- mod_req  out  1  one-cycle pulse asking for the next sample
- pwm_raw  out  1  registered comparator result, before dead time
- pwm_hi  out  1  high-side gate
- pwm_lo  out  1  low-side gate
- fault_latched  out  1  sticky fault flag

## Operation
- Reset values (rst low or rst_syn high):
  - all outputs 0
  - cmp=0
  - pending register empty
  - dead-time counter 0
  - FSM in OFF
- Sample buffering:
  - mod_valid loads min(mod, cnt_max+1) into pending and sets pend_full.
  - A second mod_valid before the valley overwrites pending (last sample wins).
- Compare update, on carryDown:
  - If pend_full: cmp ← pending, pend_full ← 0.
  - If mod_valid and carryDown occur in the same cycle, the incoming clamped sample goes straight to cmp and pend_full ← 0.
  - If no sample is pending, cmp holds its old value.
  - mod_req pulses high in the cycle after every carryDown.
- Comparator:
  - pwm_raw ← (cmp > carrier), every clk.
  - cmp=0 gives pwm_raw constant 0.
  - cmp=cnt_max+1 gives pwm_raw 1 for every carrier value ≤ cnt_max.
- Fault:
  - fault=1 sets fault_latched on the next edge.
  - fault_latched clears only on rst or rst_syn.
- Gate FSM states: OFF, DT_H, HI, DT_L, LO.
  - Any state → OFF when run=0 or fault_latched=1. This has priority over all other transitions.
  - OFF → DT_H if pwm_raw=1, else → DT_L. Load dt_cnt=dead_time.
  - DT_H: dt_cnt decrements each clk; at dt_cnt==1 → HI. If pwm_raw=0 during DT_H → DT_L with dt_cnt reloaded.
  - DT_L: mirror of DT_H, → LO.
  - HI: pwm_raw=0 → DT_L, load dead_time.
  - LO: pwm_raw=1 → DT_H, load dead_time.
- Output decode: pwm_hi = (state==HI), pwm_lo = (state==LO), both registered.
  - pwm_hi and pwm_lo are never 1 simultaneously.
  - Every hi↔lo changeover has at least dead_time cycles with both at 0.
- Raw pulses shorter than dead_time never reach the opposite gate; the FSM just restarts its dead-time wait.

## Timing
- carrier/cmp change at edge k → pwm_raw at edge k+1.
- The turn-off gate falls at edge k+2.
- The opposite gate rises at edge k+2+dead_time.
- carryDown at edge k (sampled) → cmp updated at k+1, mod_req high during cycle k+1 to k+2.
- run falling or fault_latched rising at edge k → both gates 0 at edge k+1.
- After run returns to 1 (or fault is cleared), the first gate rises dead_time+1 cycles later.
- rst is asynchronous: outputs go to 0 immediately, in mid-pulse or mid-dead-time.

## Test plan
- Reset: rst low mid-HI → pwm_hi=0 at once; after release, all outputs 0 and state OFF until run=1.
- Dead time: dead_time=3, cmp=20, carrier ramp 0..41..0 → pwm_raw high for carrier<20. Each hi/lo swap has exactly 3 both-off cycles; pwm_hi and pwm_lo are never both 1.
- Buffering: mod_valid with mod=10, then 30, before the valley → cmp=30 after carryDown, mod_req pulses once. Simultaneous mod_valid (mod=5) and carryDown → cmp=5.
- Extremes: mod=0 → pwm_lo steady after dead time. mod=63 → clamped to 42, pwm_hi steady.
- Short pulse: raw high for 2 cycles with dead_time=3 while in LO → LO→DT_H→DT_L→LO; pwm_hi never asserts.
- Fault: fault pulse of 1 cycle in HI → both off next cycle, fault_latched=1 persists; rst_syn clears it; re-entry waits 3 cycles.
